// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sequencer sharing one data-memory datapath among N_REQ requesters.
// Optional misaligned-access rejection is enabled by defining DMEM_ARB_MISALIGN_CHECK_EN.
module dmem_arbiter #(
  parameter int N_REQ = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    req_we,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_wdata,
  input  logic [N_REQ*3-1:0]  req_load_type,
  input  logic [N_REQ*2-1:0]  req_store_type,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]       rsp_rdata,
  output logic                rsp_err,
  output logic                mem_read,
  output logic                mem_write,
  output logic [2:0]          mem_load_type,
  output logic [1:0]          mem_store_type,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  input  logic [DW-1:0]       mem_rdata
);
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state, state_nx;
  logic [IW-1:0] last_owner, owner, win_idx;
  logic found, l_we, mis;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic [2:0] l_lt;
  logic [1:0] l_st;
  // search starts just after the previous owner so a busy port cannot starve the rest
  always_comb begin
    found = 1'b0;
    win_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found && req[(int'(last_owner) + k) % N_REQ]) begin
        found = 1'b1;
        win_idx = IW'((int'(last_owner) + k) % N_REQ);
      end
    end
  end
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (found ? ISSUE : IDLE) : state == ISSUE ? RESP : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_owner <= IW'(N_REQ - 1);
      owner      <= '0;
      l_we       <= 1'b0;
      l_addr     <= '0;
      l_wdata    <= '0;
      l_lt       <= '0;
      l_st       <= '0;
    end else if (state == IDLE && found) begin
      last_owner <= win_idx;
      owner      <= win_idx;
      l_we       <= req_we[win_idx];
      l_addr     <= req_addr[win_idx*AW +: AW];
      l_wdata    <= req_wdata[win_idx*DW +: DW];
      l_lt       <= req_load_type[win_idx*3 +: 3];
      l_st       <= req_store_type[win_idx*2 +: 2];
    end
  end
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
  assign mis = l_we ? ((l_st == 2'b01 && l_addr[0]) || (l_st == 2'b10 && |l_addr[1:0]))
                    : (((l_lt == 3'b001 || l_lt == 3'b100) && l_addr[0]) || (l_lt == 3'b010 && |l_addr[1:0]));
`else
  assign mis = 1'b0;
`endif
  assign gnt            = (state == IDLE && found) ? N_REQ'(1) << win_idx : '0;
  assign mem_read       = state == ISSUE && !l_we && !mis;
  assign mem_write      = state == ISSUE && l_we && !mis;
  assign mem_addr       = l_addr;
  assign mem_wdata      = l_wdata;
  assign mem_load_type  = l_lt;
  assign mem_store_type = l_st;
  assign rsp_valid      = state == RESP ? N_REQ'(1) << owner : '0;
  assign rsp_rdata      = (state == RESP && !l_we && !mis) ? mem_rdata : '0;
  assign rsp_err        = state == RESP && mis;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table plus contention and reset-in-ISSUE sequences.
module tb_dmem_arbiter;
  localparam int N = 2;
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req = '0, req_we = '0, gnt, rsp_valid;
  logic [N*32-1:0] req_addr = '0, req_wdata = '0;
  logic [N*3-1:0] req_load_type = '0;
  logic [N*2-1:0] req_store_type = '0;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic rsp_err, mem_read, mem_write;
  logic [2:0] mem_load_type;
  logic [1:0] mem_store_type;
  logic [7:0] mem [0:255];
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  dmem_arbiter #(.N_REQ(N), .AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_load_type(req_load_type), .req_store_type(req_store_type),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_load_type(mem_load_type),
    .mem_store_type(mem_store_type), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );
  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  always @(posedge clk) begin
    logic [7:0] a;
    logic [31:0] w;
    a = mem_addr[7:0];
    w = {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
    if (mem_write) begin
      mem[a] <= mem_wdata[7:0];
      if (mem_store_type != 2'b00) mem[a + 8'd1] <= mem_wdata[15:8];
      if (mem_store_type == 2'b10) begin
        mem[a + 8'd2] <= mem_wdata[23:16];
        mem[a + 8'd3] <= mem_wdata[31:24];
      end
    end
    if (mem_read)
      mem_rdata <= mem_load_type == 3'b000 ? {{24{w[7]}}, w[7:0]} :
                   mem_load_type == 3'b001 ? {{16{w[15]}}, w[15:0]} :
                   mem_load_type == 3'b011 ? {24'h0, w[7:0]} :
                   mem_load_type == 3'b100 ? {16'h0, w[15:0]} : w;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  typedef struct {
    int p; logic we; logic [31:0] addr, wdata; logic [2:0] lt; logic [1:0] st;
    logic [31:0] exp_rd; logic exp_err;
  } vec_t;
  vec_t v [12];
  initial begin
    v[0]  = '{0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd0, 2'd2, 32'h0, 1'b0};
    v[1]  = '{0, 1'b0, 32'h10, 32'h0, 3'd2, 2'd0, 32'hDEADBEEF, 1'b0};
    v[2]  = '{1, 1'b1, 32'h20, 32'h000080F0, 3'd0, 2'd2, 32'h0, 1'b0};
    v[3]  = '{1, 1'b0, 32'h20, 32'h0, 3'd0, 2'd0, 32'hFFFFFFF0, 1'b0};
    v[4]  = '{1, 1'b0, 32'h20, 32'h0, 3'd3, 2'd0, 32'h000000F0, 1'b0};
    v[5]  = '{1, 1'b0, 32'h20, 32'h0, 3'd1, 2'd0, 32'hFFFF80F0, 1'b0};
    v[6]  = '{1, 1'b0, 32'h20, 32'h0, 3'd4, 2'd0, 32'h000080F0, 1'b0};
    v[7]  = '{0, 1'b0, 32'h13, 32'h0, 3'd2, 2'd0, CHK ? 32'h0 : 32'h000000DE, CHK};
    v[8]  = '{1, 1'b1, 32'h21, 32'h00001234, 3'd0, 2'd1, 32'h0, CHK};
    v[9]  = '{0, 1'b0, 32'h20, 32'h0, 3'd2, 2'd0, CHK ? 32'h000080F0 : 32'h001234F0, 1'b0};
    v[10] = '{0, 1'b1, 32'h12, 32'h00000055, 3'd0, 2'd0, 32'h0, 1'b0};
    v[11] = '{1, 1'b0, 32'h10, 32'h0, 3'd2, 2'd0, 32'hDE55BEEF, 1'b0};
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_mem_rw", {mem_read, mem_write}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      req = '0;
      req[v[i].p] = 1'b1;
      req_we[v[i].p] = v[i].we;
      req_addr[v[i].p*32 +: 32] = v[i].addr;
      req_wdata[v[i].p*32 +: 32] = v[i].wdata;
      req_load_type[v[i].p*3 +: 3] = v[i].lt;
      req_store_type[v[i].p*2 +: 2] = v[i].st;
      #1;
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(1) << v[i].p);
      @(negedge clk);
      req = '0;
      #1;
      chk($sformatf("v%0d_issue_rw", i), {mem_read, mem_write},
          v[i].exp_err ? 32'd0 : (v[i].we ? 32'd1 : 32'd2));
      chk($sformatf("v%0d_issue_addr", i), mem_addr, v[i].addr);
      chk($sformatf("v%0d_issue_rsp", i), 32'(rsp_valid), 0);
      chk($sformatf("v%0d_issue_gnt", i), 32'(gnt), 0);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(1) << v[i].p);
      chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata, v[i].exp_rd);
      chk($sformatf("v%0d_rsp_err", i), 32'(rsp_err), 32'(v[i].exp_err));
      chk($sformatf("v%0d_resp_rw", i), {mem_read, mem_write}, 0);
    end
    // contention: both ports continuously requesting loads
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_we = '0;
    req_addr = {32'h20, 32'h10};
    req_load_type = {3'd2, 3'd2};
    req = 2'b11;
    for (int c = 0; c < 12; c++) begin
      logic [1:0] own;
      own = ((c / 3) % 2) ? 2'b10 : 2'b01;
      #1;
      chk($sformatf("cont%0d_gnt", c), 32'(gnt), (c % 3 == 0) ? 32'(own) : 0);
      chk($sformatf("cont%0d_rsp", c), 32'(rsp_valid), (c % 3 == 2) ? 32'(own) : 0);
      if (c % 3 == 2)
        chk($sformatf("cont%0d_rdata", c), rsp_rdata,
            own[0] ? 32'hDE55BEEF : (CHK ? 32'h000080F0 : 32'h001234F0));
      @(negedge clk);
    end
    req = '0;
    repeat (3) @(negedge clk);
    // reset taken in ISSUE after port 0 owned the last grant
    req = 2'b01;
    #1;
    chk("rsti_gnt", 32'(gnt), 32'd1);
    @(negedge clk);
    req = '0;
    rst_n = 1'b0;
    #1;
    chk("rsti_issue_read", 32'(mem_read), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rsti_after_read", 32'(mem_read), 0);
    chk("rsti_after_rsp", 32'(rsp_valid), 0);
    @(negedge clk);
    req = 2'b11;
    #1;
    chk("rsti_rsp_gone", 32'(rsp_valid), 0);
    chk("rsti_first_gnt", 32'(gnt), 32'd1);
    @(negedge clk);
    req = '0;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
